alu_pipe: RTL

- Parametrised, two-stage pipelined successor to the combinational datapath ALU.
- Same opcode map: register ALU, immediate ALU and branch-compare operations.
- Adds valid/ready handshakes on both sides, a registered result with flags, and a tag passthrough.
- Sits between the decode stage and writeback/branch unit of the core.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_mul_seq.sv | 81 ++++++++
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, decode helpers and multiplier FSM encoding shared by alu_pipe.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [3:0] OPC_NOP  = 4'b0000;
  localparam logic [3:0] OPC_XOR  = 4'b0001;
  localparam logic [3:0] OPC_OR   = 4'b0010;
  localparam logic [3:0] OPC_AND  = 4'b0011;
  localparam logic [3:0] OPC_ADD  = 4'b0100;
  localparam logic [3:0] OPC_ADDI = 4'b0101;
  localparam logic [3:0] OPC_ORI  = 4'b0110;
  localparam logic [3:0] OPC_XORI = 4'b0111;
  localparam logic [3:0] OPC_ANDI = 4'b1000;
  localparam logic [3:0] OPC_BEQ  = 4'b1001;
  localparam logic [3:0] OPC_BNE  = 4'b1010;
  localparam logic [3:0] OPC_BLT  = 4'b1011;
  localparam logic [3:0] OPC_BGE  = 4'b1100;
  localparam logic [3:0] OPC_MUL  = 4'b1101;
  localparam logic [3:0] OPC_BLTU = 4'b1110;
  localparam logic [3:0] OPC_RSVD = 4'b1111;

  // Sequential multiplier states: idle, shifting/adding, one-cycle completion
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Branch-compare ops produce i0 - i1 and drive the jump flag
  function automatic logic is_branch(input logic [3:0] opc);
    return (opc == OPC_BEQ) || (opc == OPC_BNE) || (opc == OPC_BLT) ||
           (opc == OPC_BGE) || (opc == OPC_BLTU);
  endfunction

  // Immediate ops take the extended immediate as operand B
  function automatic logic is_imm(input logic [3:0] opc);
    return (opc == OPC_ADDI) || (opc == OPC_ORI) || (opc == OPC_XORI) ||
           (opc == OPC_ANDI);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: DATA_W-cycle unsigned shift-add multiplier, low DATA_W bits of a*b.
// Only present when ALU_PIPE_MUL_EN is defined.
// done is a lookahead strobe on the final iteration so the caller can capture
// product on the same edge the FSM enters MUL_DONE.
`timescale 1ns/1ps
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);

  mul_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic              r_busy;
  logic [DATA_W-1:0] w_accNext;

  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign done      = (r_state == MUL_RUN) && (r_cnt == '0);
  assign product   = w_accNext;
  assign busy      = r_busy;

  // Multiplier FSM: one multiplier bit consumed per cycle, counter runs DATA_W-1 down to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MUL_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (start) begin
            r_state  <= MUL_RUN;
            r_cnt    <= CNT_W'(DATA_W - 1);
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_busy   <= 1'b1;
          end
        end
        MUL_RUN: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == '0) begin
            r_state <= MUL_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        MUL_DONE: begin
          r_state <= MUL_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= MUL_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides, registered
// result/flags and tag passthrough. S1 holds the decoded op, S2 holds the result.
// Optional feature macro: ALU_PIPE_MUL_EN (opcode 1101 becomes a sequential MUL).
`timescale 1ns/1ps
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W   = 20,
  parameter int IMM_W    = 8,
  parameter int IMM_SEXT = 0,
  parameter int TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opc,
  input  logic [DATA_W-1:0] in_i0,
  input  logic [DATA_W-1:0] in_i1,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_jump,
  output logic              out_carry,
  output logic              out_zero,
  output logic [TAG_W-1:0]  out_tag
);

  logic              r_s1Valid;
  logic [3:0]        r_s1Opc;
  logic [DATA_W-1:0] r_s1A;
  logic [DATA_W-1:0] r_s1B;
  logic [TAG_W-1:0]  r_s1Tag;

  logic              r_s2Valid;
  logic [DATA_W-1:0] r_s2Result;
  logic              r_s2Jump;
  logic              r_s2Carry;
  logic              r_s2Zero;
  logic [TAG_W-1:0]  r_s2Tag;

  logic [DATA_W-1:0] w_immExt;
  logic [DATA_W-1:0] w_selB;
  logic              w_s2Free;
  logic              w_s1Adv;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_jump;
  logic              w_carry;

  logic              w_mulStart;
  logic              w_mulBusy;
  logic              w_mulDone;
  logic [DATA_W-1:0] w_mulProduct;
  logic [TAG_W-1:0]  w_mulTag;

  generate
    if (IMM_SEXT != 0) begin : g_immSext
      assign w_immExt = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    end else begin : g_immZext
      assign w_immExt = {{(DATA_W-IMM_W){1'b0}}, in_imm};
    end
  endgenerate

  assign w_selB   = is_imm(in_opc) ? w_immExt : in_i1;
  assign w_s2Free = !r_s2Valid || out_ready;
  assign w_s1Adv  = w_s2Free && !w_mulBusy;
  assign in_ready = !r_s1Valid || w_s1Adv;

`ifdef ALU_PIPE_MUL_EN
  logic [TAG_W-1:0] r_mulTag;

  assign w_mulStart = w_s1Adv && r_s1Valid && (r_s1Opc == OPC_MUL);
  assign w_mulTag   = r_mulTag;

  // Keep the tag of the op handed to the multiplier until its product lands in S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mulTag <= '0;
    end else if (w_mulStart) begin
      r_mulTag <= r_s1Tag;
    end
  end

  alu_mul_seq #(
    .DATA_W(DATA_W)
  ) u_mulSeq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mulStart),
    .a       (r_s1A),
    .b       (r_s1B),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_mulProduct)
  );
`else
  assign w_mulStart   = 1'b0;
  assign w_mulBusy    = 1'b0;
  assign w_mulDone    = 1'b0;
  assign w_mulProduct = '0;
  assign w_mulTag     = '0;
`endif

  // S1: capture opcode, operand A, selected operand B and tag whenever S1 is free or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Opc   <= OPC_NOP;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Tag   <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Opc <= in_opc;
        r_s1A   <= in_i0;
        r_s1B   <= w_selB;
        r_s1Tag <= in_tag;
      end
    end
  end

  // Combinational evaluation of the op held in S1; reserved codes and MUL yield zero here
  always_comb begin
    w_sum    = {1'b0, r_s1A} + {1'b0, r_s1B};
    w_diff   = r_s1A - r_s1B;
    w_result = '0;
    w_jump   = 1'b0;
    w_carry  = 1'b0;
    if (is_branch(r_s1Opc)) begin
      w_result = w_diff;
    end
    case (r_s1Opc)
      OPC_XOR, OPC_XORI: w_result = r_s1A ^ r_s1B;
      OPC_OR,  OPC_ORI:  w_result = r_s1A | r_s1B;
      OPC_AND, OPC_ANDI: w_result = r_s1A & r_s1B;
      OPC_ADD, OPC_ADDI: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
      end
      OPC_BEQ:  w_jump = (r_s1A == r_s1B);
      OPC_BNE:  w_jump = (r_s1A != r_s1B);
      OPC_BLT:  w_jump = ($signed(r_s1A) <  $signed(r_s1B));
      OPC_BGE:  w_jump = ($signed(r_s1A) >= $signed(r_s1B));
      OPC_BLTU: w_jump = (r_s1A < r_s1B);
      OPC_NOP, OPC_MUL, OPC_RSVD: w_result = '0;
      default: w_result = '0;
    endcase
  end

  // S2: registered result and flags; holds while out_valid is stalled, takes the product when MUL finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid  <= 1'b0;
      r_s2Result <= '0;
      r_s2Jump   <= 1'b0;
      r_s2Carry  <= 1'b0;
      r_s2Zero   <= 1'b1;
      r_s2Tag    <= '0;
    end else if (w_mulDone) begin
      r_s2Valid  <= 1'b1;
      r_s2Result <= w_mulProduct;
      r_s2Jump   <= 1'b0;
      r_s2Carry  <= 1'b0;
      r_s2Zero   <= (w_mulProduct == '0);
      r_s2Tag    <= w_mulTag;
    end else if (w_s1Adv) begin
      r_s2Valid <= r_s1Valid && !w_mulStart;
      if (r_s1Valid && !w_mulStart) begin
        r_s2Result <= w_result;
        r_s2Jump   <= w_jump;
        r_s2Carry  <= w_carry;
        r_s2Zero   <= (w_result == '0);
        r_s2Tag    <= r_s1Tag;
      end
    end
  end

  assign out_valid  = r_s2Valid;
  assign out_result = r_s2Result;
  assign out_jump   = r_s2Jump;
  assign out_carry  = r_s2Carry;
  assign out_zero   = r_s2Zero;
  assign out_tag    = r_s2Tag;

endmodule
